// File: rtl/gb_apu_pkg.sv
// Shared Game Boy APU definitions: duty waveforms, field widths, frequency base,
// and the sweep adder used by the pulse channels.
package gb_apu_pkg;

  localparam int FREQ_W    = 11;
  localparam int VOL_W     = 4;
  localparam int LEN_W     = 6;
  localparam int FREQ_BASE = 2048;

  // Written left to right as duty positions 0..7, so position p is bit [7-p].
  localparam logic [7:0] DUTY_PAT [4] = '{8'b00000001, 8'b10000001,
                                          8'b10000111, 8'b01111110};

  function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0] shadow,
                                                 input logic [2:0]        shift,
                                                 input logic              negate);
    logic [FREQ_W:0] base;
    logic [FREQ_W:0] delta;
    base  = {1'b0, shadow};
    delta = base >> shift;
    return negate ? (base - delta) : (base + delta);
  endfunction

endpackage

// File: rtl/pulse_envelope.sv
// Volume envelope shared by the pulse channels: loads on trigger and steps the
// volume by one, saturating, every `period` envelope ticks.
module pulse_envelope
  import gb_apu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             tick,
  input  logic [VOL_W-1:0] start_vol,
  input  logic [2:0]       period,
  input  logic             env_add,
  output logic [VOL_W-1:0] vol
);

  logic [VOL_W-1:0] vol_q, vol_d;
  logic [2:0]       etmr_q, etmr_d;

  always_comb begin
    vol_d  = vol_q;
    etmr_d = etmr_q;
    if (trig) begin
      vol_d  = start_vol;
      etmr_d = period;
    end else if (tick && period != 3'd0) begin
      if (etmr_q <= 3'd1) begin
        etmr_d = period;
        if (env_add && vol_q != '1)
          vol_d = vol_q + 1'b1;
        else if (!env_add && vol_q != '0)
          vol_d = vol_q - 1'b1;
      end else begin
        etmr_d = etmr_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vol_q  <= '0;
      etmr_q <= '0;
    end else begin
      vol_q  <= vol_d;
      etmr_q <= etmr_d;
    end
  end

  assign vol = vol_q;

endmodule

// File: rtl/pulse_channel1.sv
// Game Boy square channel 1: duty generator, length counter, envelope and
// frequency sweep. The sweep unit is built only when PULSE_SWEEP_EN is defined.
module pulse_channel1
  import gb_apu_pkg::*;
#(
  parameter int FREQ_MULT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk256,
  input  logic              clk128,
  input  logic              clk64,
  input  logic [2:0]        swpPd,
  input  logic              negate,
  input  logic [2:0]        shift,
  input  logic [FREQ_W-1:0] freq,
  input  logic [LEN_W-1:0]  lenLoad,
  input  logic [1:0]        duty,
  input  logic [VOL_W-1:0]  startVol,
  input  logic [2:0]        period,
  input  logic              lenEnable,
  input  logic              trigger,
  input  logic              envAdd,
  output logic [VOL_W-1:0]  out,
  output logic              enabled
);

  localparam int TMR_W   = $clog2(FREQ_BASE * FREQ_MULT + 1);
  localparam int LEN_MAX = 1 << LEN_W;

  function automatic logic [TMR_W-1:0] step_len(input logic [FREQ_W-1:0] f);
    return TMR_W'((FREQ_BASE - int'(f)) * FREQ_MULT);
  endfunction

  logic clk256_q, clk128_q, clk64_q, trigger_q;
  logic ev256, ev128, ev64, ev_trig;

  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [2:0]        pos_q, pos_d;
  logic [FREQ_W-1:0] freq_r_q, freq_r_d;
  logic [LEN_W:0]    len_q, len_d;
  logic              enabled_q, enabled_d;
  logic [VOL_W-1:0]  out_q, out_d;
  logic [VOL_W-1:0]  vol;

  // An event is a rising edge between the previous and the current sample.
  assign ev256   = clk256  & ~clk256_q;
  assign ev128   = clk128  & ~clk128_q;
  assign ev64    = clk64   & ~clk64_q;
  assign ev_trig = trigger & ~trigger_q;

  pulse_envelope u_env (
    .clk       (clk),
    .rst       (rst),
    .trig      (ev_trig),
    .tick      (ev64),
    .start_vol (startVol),
    .period    (period),
    .env_add   (envAdd),
    .vol       (vol)
  );

`ifdef PULSE_SWEEP_EN
  logic [FREQ_W-1:0] shadow_q, shadow_d;
  logic [3:0]        swp_tmr_q, swp_tmr_d;
  logic              sweep_on_q, sweep_on_d;
  logic [FREQ_W:0]   swp_new, swp_next;
  logic [3:0]        swp_reload;

  assign swp_reload = (swpPd == 3'd0) ? 4'd8 : {1'b0, swpPd};
`else
  logic unused_sweep;
  assign unused_sweep = ^{swpPd, negate, shift, ev128};
`endif

  always_comb begin
    tmr_d     = tmr_q;
    pos_d     = pos_q;
    freq_r_d  = freq_r_q;
    len_d     = len_q;
    enabled_d = enabled_q;
`ifdef PULSE_SWEEP_EN
    shadow_d   = shadow_q;
    swp_tmr_d  = swp_tmr_q;
    sweep_on_d = sweep_on_q;
    swp_new    = '0;
    swp_next   = '0;
`endif

    if (tmr_q <= TMR_W'(1)) begin
      tmr_d = step_len(freq_r_q);
      pos_d = pos_q + 3'd1;
    end else begin
      tmr_d = tmr_q - TMR_W'(1);
    end

    if (ev_trig) begin
      enabled_d = 1'b1;
      len_d     = (LEN_W+1)'(LEN_MAX) - {1'b0, lenLoad};
      freq_r_d  = freq;
      tmr_d     = step_len(freq);
      pos_d     = 3'd0;
`ifdef PULSE_SWEEP_EN
      shadow_d   = freq;
      swp_tmr_d  = swp_reload;
      sweep_on_d = (swpPd != 3'd0) || (shift != 3'd0);
      swp_new    = sweep_calc(freq, shift, negate);
      if (shift != 3'd0 && swp_new > (FREQ_W+1)'(FREQ_BASE - 1))
        enabled_d = 1'b0;
`endif
      if (startVol == '0 && !envAdd)
        enabled_d = 1'b0;
    end else begin
      if (ev256 && lenEnable && len_q != '0) begin
        len_d = len_q - 1'b1;
        if (len_q == (LEN_W+1)'(1))
          enabled_d = 1'b0;
      end
`ifdef PULSE_SWEEP_EN
      if (ev128) begin
        if (swp_tmr_q <= 4'd1) begin
          swp_tmr_d = swp_reload;
          if (sweep_on_q && swpPd != 3'd0) begin
            swp_new = sweep_calc(shadow_q, shift, negate);
            if (swp_new > (FREQ_W+1)'(FREQ_BASE - 1)) begin
              enabled_d = 1'b0;
            end else if (shift != 3'd0) begin
              shadow_d = swp_new[FREQ_W-1:0];
              freq_r_d = swp_new[FREQ_W-1:0];
              // Second overflow check on the freshly written value; result is discarded.
              swp_next = sweep_calc(swp_new[FREQ_W-1:0], shift, negate);
              if (swp_next > (FREQ_W+1)'(FREQ_BASE - 1))
                enabled_d = 1'b0;
            end
          end
        end else begin
          swp_tmr_d = swp_tmr_q - 4'd1;
        end
      end
`endif
    end

    out_d = (enabled_q && DUTY_PAT[duty][3'd7 - pos_q]) ? vol : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk256_q  <= 1'b0;
      clk128_q  <= 1'b0;
      clk64_q   <= 1'b0;
      trigger_q <= 1'b0;
      tmr_q     <= '0;
      pos_q     <= '0;
      freq_r_q  <= '0;
      len_q     <= '0;
      enabled_q <= 1'b0;
      out_q     <= '0;
`ifdef PULSE_SWEEP_EN
      shadow_q   <= '0;
      swp_tmr_q  <= '0;
      sweep_on_q <= 1'b0;
`endif
    end else begin
      clk256_q  <= clk256;
      clk128_q  <= clk128;
      clk64_q   <= clk64;
      trigger_q <= trigger;
      tmr_q     <= tmr_d;
      pos_q     <= pos_d;
      freq_r_q  <= freq_r_d;
      len_q     <= len_d;
      enabled_q <= enabled_d;
      out_q     <= out_d;
`ifdef PULSE_SWEEP_EN
      shadow_q   <= shadow_d;
      swp_tmr_q  <= swp_tmr_d;
      sweep_on_q <= sweep_on_d;
`endif
    end
  end

  assign out     = out_q;
  assign enabled = enabled_q;

endmodule

// File: tb/tb_pulse_channel1.sv
// Randomized self-checking bench for pulse_channel1 against an arithmetic model
// of the duty waveform, length counter, envelope and sweep overflow rules.
module tb_pulse_channel1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk256 = 1'b0, clk128 = 1'b0, clk64 = 1'b0;
  logic [2:0]  swpPd = '0, shift = '0, period = '0;
  logic        negate = 1'b0, lenEnable = 1'b0, trigger = 1'b0, envAdd = 1'b0;
  logic [10:0] freq = '0;
  logic [5:0]  lenLoad = '0;
  logic [1:0]  duty = '0;
  logic [3:0]  startVol = '0;
  logic [3:0]  out;
  logic        enabled;

  int n_checks = 0;
  int n_pass   = 0;

  // Duty waveforms, listed by position 0..7.
  int pat [4][8] = '{'{0,0,0,0,0,0,0,1},
                     '{1,0,0,0,0,0,0,1},
                     '{1,0,0,0,0,1,1,1},
                     '{0,1,1,1,1,1,1,0}};

  always #5 clk = ~clk;

  pulse_channel1 #(.FREQ_MULT(4)) dut (
    .clk(clk), .rst(rst), .clk256(clk256), .clk128(clk128), .clk64(clk64),
    .swpPd(swpPd), .negate(negate), .shift(shift), .freq(freq),
    .lenLoad(lenLoad), .duty(duty), .startVol(startVol), .period(period),
    .lenEnable(lenEnable), .trigger(trigger), .envAdd(envAdd),
    .out(out), .enabled(enabled)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic strobe(input int which);
    if (which == 0) clk256 = 1'b1; else if (which == 1) clk128 = 1'b1; else clk64 = 1'b1;
    @(negedge clk);
    clk256 = 1'b0; clk128 = 1'b0; clk64 = 1'b0;
    @(negedge clk);
  endtask

  task automatic setup(input int f, input int d, input int v, input int add, input int per,
                       input int lload, input int len_en, input int spd, input int sh,
                       input int neg);
    freq = 11'(f); duty = 2'(d); startVol = 4'(v); envAdd = 1'(add); period = 3'(per);
    lenLoad = 6'(lload); lenEnable = 1'(len_en); swpPd = 3'(spd); shift = 3'(sh);
    negate = 1'(neg);
    @(negedge clk);
  endtask

  task automatic peak(output int m);
    m = 0;
    repeat (40) begin
      @(negedge clk);
      if (int'(out) > m) m = int'(out);
    end
  endtask

  // Samples the middle of each duty step after a trigger.
  task automatic run_tone(input int f, input int d, input int v);
    int n;
    setup(f, d, v, 0, 0, 0, 0, 0, 0, 0);
    n = (2048 - f) * 4;
    fire_trigger();
    chk("tone_enabled", int'(enabled), 1);
    cycles(n / 2 - 1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("tone f%0d d%0d step%0d", f, d, k), int'(out), pat[d][k % 8] ? v : 0);
      cycles(n);
    end
  endtask

  initial begin
    int m, ll, s, a, p, vol_m, f, sh, sh_model, nv;
    bit on;

    cycles(3);
    chk("reset_out", int'(out), 0);
    chk("reset_enabled", int'(enabled), 0);
    rst = 1'b0;
    cycles(2);

    run_tone(1920, 2, 15);
    for (int i = 0; i < 5; i++)
      run_tone($urandom_range(1950, 2030), $urandom_range(0, 3), $urandom_range(1, 15));

    // Length counter
    for (int i = 0; i < 4; i++) begin
      ll = (i == 0) ? 62 : $urandom_range(56, 63);
      setup(2047, 3, 15, 0, 0, ll, 1, 0, 0, 0);
      fire_trigger();
      repeat (64 - ll - 1) strobe(0);
      chk($sformatf("len%0d_before_end", ll), int'(enabled), 1);
      strobe(0);
      chk($sformatf("len%0d_expired", ll), int'(enabled), 0);
      peak(m);
      chk($sformatf("len%0d_out", ll), m, 0);
    end
    setup(2047, 3, 15, 0, 0, 63, 0, 0, 0, 0);
    fire_trigger();
    repeat (3) strobe(0);
    chk("len_disabled_counter", int'(enabled), 1);

    // Envelope
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin s = 8; a = 0; p = 1; end
      else if (i == 1) begin s = 14; a = 1; p = 1; end
      else begin
        a = $urandom_range(0, 1); p = $urandom_range(1, 3);
        s = $urandom_range(1, 15);
      end
      setup(2047, 3, s, a, p, 0, 0, 0, 0, 0);
      fire_trigger();
      peak(m);
      chk($sformatf("env s%0d a%0d p%0d tick0", s, a, p), m, s);
      for (int k = 1; k <= 18; k++) begin
        strobe(2);
        if (k % 3 == 0) begin
          vol_m = a ? s + k / p : s - k / p;
          if (vol_m > 15) vol_m = 15;
          if (vol_m < 0) vol_m = 0;
          peak(m);
          chk($sformatf("env s%0d a%0d p%0d tick%0d", s, a, p, k), m, vol_m);
        end
      end
    end

`ifdef PULSE_SWEEP_EN
    setup(2000, 3, 15, 0, 0, 0, 0, 0, 1, 0);
    fire_trigger();
    chk("sweep_trigger_overflow", int'(enabled), 0);
    setup(1024, 3, 15, 0, 0, 0, 0, 1, 1, 0);
    fire_trigger();
    chk("sweep_1024_start", int'(enabled), 1);
    strobe(1);
    chk("sweep_1024_followup_overflow", int'(enabled), 0);
    for (int i = 0; i < 4; i++) begin
      f = $urandom_range(300, 1400); sh = $urandom_range(1, 7);
      on = !((f + (f >> sh)) > 2047);
      setup(f, 3, 15, 0, 0, 0, 0, 1, sh, 0);
      fire_trigger();
      chk($sformatf("sweep f%0d sh%0d trig", f, sh), int'(enabled), int'(on));
      sh_model = f;
      for (int k = 0; k < 4; k++) begin
        strobe(1);
        if (on) begin
          nv = sh_model + (sh_model >> sh);
          if (nv > 2047) on = 0;
          else begin
            sh_model = nv;
            if (nv + (nv >> sh) > 2047) on = 0;
          end
        end
        chk($sformatf("sweep f%0d sh%0d tick%0d", f, sh, k), int'(enabled), int'(on));
      end
    end
    setup($urandom_range(100, 2047), 3, 15, 0, 0, 0, 0, 1, $urandom_range(1, 7), 1);
    fire_trigger();
    repeat (4) strobe(1);
    chk("sweep_negate_stays_on", int'(enabled), 1);
`else
    setup(2000, 3, 15, 0, 0, 0, 0, 0, 1, 0);
    fire_trigger();
    chk("nosweep_no_overflow", int'(enabled), 1);
    setup(1024, 3, 15, 0, 0, 0, 0, 1, 1, 0);
    fire_trigger();
    repeat (3) strobe(1);
    chk("nosweep_ignores_clk128", int'(enabled), 1);
`endif

    // DAC off
    setup(1920, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    fire_trigger();
    chk("dac_off_enabled", int'(enabled), 0);
    peak(m);
    chk("dac_off_out", m, 0);

    // Reset mid-tone, then restart
    setup(1920, 2, 15, 0, 0, 0, 0, 0, 0, 0);
    fire_trigger();
    cycles(700);
    rst = 1'b1;
    @(negedge clk);
    chk("midtone_reset_out", int'(out), 0);
    chk("midtone_reset_enabled", int'(enabled), 0);
    rst = 1'b0;
    cycles(2);
    run_tone(1920, 2, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
